// File: rtl/pe_inst_sequencer_if.sv
// Instruction port between the sequencer and the per-PE controller.
// The names of the signals match the sequencer ports they carry.
interface pe_inst_sequencer_if;
  logic [2:0] o_opcode;
  logic [8:0] o_conv_info;
  logic       o_inst_valid;
  logic       i_inst_ready;

  modport master (
    output o_opcode,
    output o_conv_info,
    output o_inst_valid,
    input  i_inst_ready
  );

  modport slave (
    input  o_opcode,
    input  o_conv_info,
    input  o_inst_valid,
    output i_inst_ready
  );
endinterface

// File: rtl/pe_inst_sequencer.sv
// Issues SET, LOAD_WGHT, then per tile {LOAD_IFMAP, CONV} x n_iter and ACC to the PE.
// state   | meaning
// IDLE    | waiting for i_start; conv_info keeps the last accepted config
// I_SET   | SET offered to the PE
// I_WGHT  | LOAD_WGHT offered
// I_IFMAP | LOAD_IFMAP offered for the current iteration
// I_CONV  | CONV offered; its handshake advances iter or moves to ACC
// I_ACC   | ACC offered; its handshake advances tile or ends the run
// DONE    | one-cycle completion pulse
module pe_inst_sequencer #(
  parameter int CNT_BITWIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [2:0]              i_p,
  input  logic [2:0]              i_q,
  input  logic [2:0]              i_s,
  input  logic [CNT_BITWIDTH-1:0] i_n_tile,
  input  logic [CNT_BITWIDTH-1:0] i_n_iter,
  pe_inst_sequencer_if.master     inst_if,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_WGHT  = 3'd2;
  localparam logic [2:0] S_IFMAP = 3'd3;
  localparam logic [2:0] S_CONV  = 3'd4;
  localparam logic [2:0] S_ACC   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_SET   = 3'b001;
  localparam logic [2:0] OP_WGHT  = 3'b011;
  localparam logic [2:0] OP_IFMAP = 3'b010;
  localparam logic [2:0] OP_CONV  = 3'b100;
  localparam logic [2:0] OP_ACC   = 3'b101;

  localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};

  logic [2:0]              r_state;
  logic [2:0]              r_p;
  logic [2:0]              r_q;
  logic [2:0]              r_s;
  logic [CNT_BITWIDTH-1:0] r_n_tile;
  logic [CNT_BITWIDTH-1:0] r_n_iter;
  logic [CNT_BITWIDTH-1:0] r_tile;
  logic [CNT_BITWIDTH-1:0] r_iter;
  logic [2:0]              r_opcode;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;

  logic [2:0]              w_state_nxt;
  logic [CNT_BITWIDTH-1:0] w_tile_nxt;
  logic [CNT_BITWIDTH-1:0] w_iter_nxt;
  logic [2:0]              w_opcode_nxt;
  logic                    w_hs;
  logic                    w_accept;

  assign w_hs     = r_valid & inst_if.i_inst_ready;
  assign w_accept = (r_state == S_IDLE) & i_start;

  always_comb begin
    w_state_nxt = r_state;
    w_tile_nxt  = r_tile;
    w_iter_nxt  = r_iter;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_tile_nxt = '0;
          w_iter_nxt = '0;
          if ((i_n_tile == '0) || (i_n_iter == '0)) w_state_nxt = S_DONE;
          else                                       w_state_nxt = S_SET;
        end
      end
      S_SET:   if (w_hs) w_state_nxt = S_WGHT;
      S_WGHT:  if (w_hs) w_state_nxt = S_IFMAP;
      S_IFMAP: if (w_hs) w_state_nxt = S_CONV;
      S_CONV: begin
        if (w_hs) begin
          if (r_iter == r_n_iter - CNT_ONE) begin
            w_iter_nxt  = '0;
            w_state_nxt = S_ACC;
          end else begin
            w_iter_nxt  = r_iter + CNT_ONE;
            w_state_nxt = S_IFMAP;
          end
        end
      end
      S_ACC: begin
        if (w_hs) begin
          // later tiles reuse the weights already loaded, so no SET/WGHT again
          if (r_tile == r_n_tile - CNT_ONE) begin
            w_state_nxt = S_DONE;
          end else begin
            w_tile_nxt  = r_tile + CNT_ONE;
            w_state_nxt = S_IFMAP;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_opcode_nxt = OP_NONE;
    case (w_state_nxt)
      S_SET:   w_opcode_nxt = OP_SET;
      S_WGHT:  w_opcode_nxt = OP_WGHT;
      S_IFMAP: w_opcode_nxt = OP_IFMAP;
      S_CONV:  w_opcode_nxt = OP_CONV;
      S_ACC:   w_opcode_nxt = OP_ACC;
      default: w_opcode_nxt = OP_NONE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_tile   <= '0;
      r_iter   <= '0;
      r_opcode <= OP_NONE;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tile   <= w_tile_nxt;
      r_iter   <= w_iter_nxt;
      r_opcode <= w_opcode_nxt;
      r_valid  <= (w_opcode_nxt != OP_NONE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  // config stays put until the next accepted start; the PE samples it late
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p      <= '0;
      r_q      <= '0;
      r_s      <= '0;
      r_n_tile <= '0;
      r_n_iter <= '0;
    end else if (w_accept) begin
      r_p      <= i_p;
      r_q      <= i_q;
      r_s      <= i_s;
      r_n_tile <= i_n_tile;
      r_n_iter <= i_n_iter;
    end
  end

  assign inst_if.o_opcode     = r_opcode;
  assign inst_if.o_inst_valid = r_valid;
  assign inst_if.o_conv_info  = {r_p, r_q, r_s};
  assign o_busy               = r_busy;
  assign o_done               = r_done;

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Bench for pe_inst_sequencer: a queue-based model of the expected instruction stream
// checked every cycle, plus literal expectations per directed test.
module tb_pe_inst_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] p, q, s;
  logic [7:0] nt, ni;
  logic       busy, done;

  always #5 clk = ~clk;

  pe_inst_sequencer_if inst_if ();

  pe_inst_sequencer #(.CNT_BITWIDTH(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_p      (p),
    .i_q      (q),
    .i_s      (s),
    .i_n_tile (nt),
    .i_n_iter (ni),
    .inst_if  (inst_if),
    .o_busy   (busy),
    .o_done   (done)
  );

  int vectors = 0;
  int errors  = 0;

  // model state
  logic [2:0] m_q[$];
  logic [8:0] m_info = '0;
  bit         m_active = 0;
  bit         m_done_now = 0;
  bit         m_was;
  bit         chk_en = 0;
  bit         ev;
  bit         s_hs = 0;
  int         cyc = 0;

  // observation logs
  int hs_ops[$];
  int hs_cyc[$];
  int done_cnt = 0;
  int last_done_cyc = -1;
  int conv_valid_cycles = 0;
  int valid_cnt = 0;
  int st_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ev = m_active && (m_q.size() > 0);
      check("valid", inst_if.o_inst_valid, ev);
      check("opcode", inst_if.o_opcode, ev ? m_q[0] : 3'b000);
      check("conv_info", inst_if.o_conv_info, m_info);
      check("busy", busy, m_active);
      check("done", done, m_done_now);
      s_hs = ev && (inst_if.i_inst_ready === 1'b1);
      if (done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (inst_if.o_inst_valid === 1'b1) valid_cnt++;
      if (inst_if.o_inst_valid === 1'b1 && inst_if.o_opcode == 3'b100) conv_valid_cycles++;
      if (inst_if.o_inst_valid === 1'b1 && inst_if.i_inst_ready === 1'b1) begin
        hs_ops.push_back(int'(inst_if.o_opcode));
        hs_cyc.push_back(cyc);
      end
    end else begin
      s_hs = 0;
    end
  end

  // expected stream built straight from the run rules: SET, WGHT, per tile (IFMAP,CONV)*n_iter, ACC
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_active   = 0;
      m_done_now = 0;
      m_info     = '0;
    end else begin
      m_was = m_active;
      if (m_done_now) begin
        m_active   = 0;
        m_done_now = 0;
      end else if (s_hs) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done_now = 1;
      end
      if (!m_was && start) begin
        m_info   = {p, q, s};
        m_active = 1;
        m_q.delete();
        if (nt == 0 || ni == 0) begin
          m_done_now = 1;
        end else begin
          m_q.push_back(3'b001);
          m_q.push_back(3'b011);
          for (int t = 0; t < int'(nt); t++) begin
            for (int i = 0; i < int'(ni); i++) begin
              m_q.push_back(3'b010);
              m_q.push_back(3'b100);
            end
            m_q.push_back(3'b101);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    hs_ops.delete();
    hs_cyc.delete();
    done_cnt = 0;
    last_done_cyc = -1;
    conv_valid_cycles = 0;
    valid_cnt = 0;
  endtask

  task automatic start_run(input logic [2:0] ap, input logic [2:0] aq, input logic [2:0] as_,
                           input logic [7:0] ant, input logic [7:0] ani);
    p = ap; q = aq; s = as_; nt = ant; ni = ani;
    start = 1'b1;
    st_cyc = cyc;
    tick();
    start = 1'b0;
    p = 3'b111; q = 3'b111; s = 3'b111; nt = 8'hAA; ni = 8'h55;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((m_active || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic wait_conv(input string name);
    int n = 0;
    while (!(inst_if.o_inst_valid === 1'b1 && inst_if.o_opcode == 3'b100) && n < 30) begin
      tick();
      n++;
    end
    check(name, (n < 30), 1);
  endtask

  task automatic t1_checks(input string tag);
    int exp_ops[5] = '{1, 3, 2, 4, 5};
    check({tag, "_hs_count"}, hs_ops.size(), 5);
    for (int k = 0; k < 5; k++)
      check({tag, "_op"}, (k < hs_ops.size()) ? hs_ops[k] : -1, exp_ops[k]);
    if (hs_cyc.size() == 5) begin
      check({tag, "_first_hs_cycle"}, hs_cyc[0], st_cyc + 1);
      check({tag, "_consecutive"}, hs_cyc[4] - hs_cyc[0], 4);
      check({tag, "_done_after_acc"}, last_done_cyc, hs_cyc[4] + 1);
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_info"}, inst_if.o_conv_info, 9'o233);
  endtask

  initial begin
    int exp3[16] = '{1, 3, 2, 4, 2, 4, 2, 4, 5, 2, 4, 2, 4, 2, 4, 5};
    int n_conv;
    rst = 1'b1; start = 1'b0;
    p = '0; q = '0; s = '0; nt = '0; ni = '0;
    inst_if.i_inst_ready = 1'b0;
    tick();
    chk_en = 1;
    tick();
    check("rst_opcode", inst_if.o_opcode, 3'b000);
    check("rst_valid", inst_if.o_inst_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_info", inst_if.o_conv_info, 0);
    rst = 1'b0;
    tick();

    // T1: single tile, single iteration, ready held high
    clear_logs();
    inst_if.i_inst_ready = 1'b1;
    start_run(3'd2, 3'd3, 3'd3, 8'd1, 8'd1);
    wait_idle("t1_timeout", 50);
    t1_checks("t1");
    tick();

    // T2: stall CONV for 5 cycles
    clear_logs();
    inst_if.i_inst_ready = 1'b1;
    start_run(3'd2, 3'd3, 3'd3, 8'd1, 8'd1);
    wait_conv("t2_conv_seen");
    inst_if.i_inst_ready = 1'b0;
    repeat (5) tick();
    inst_if.i_inst_ready = 1'b1;
    wait_idle("t2_timeout", 50);
    check("t2_conv_valid_cycles", conv_valid_cycles, 6);
    n_conv = 0;
    foreach (hs_ops[k]) if (hs_ops[k] == 4) n_conv++;
    check("t2_conv_hs", n_conv, 1);
    check("t2_hs_count", hs_ops.size(), 5);
    check("t2_done_count", done_cnt, 1);
    tick();

    // T3: two tiles, three iterations, random ready
    clear_logs();
    start_run(3'd1, 3'd2, 3'd4, 8'd2, 8'd3);
    begin
      int n = 0;
      while ((m_active || busy !== 1'b0) && n < 400) begin
        inst_if.i_inst_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      check("t3_timeout", (n < 400), 1);
    end
    inst_if.i_inst_ready = 1'b1;
    check("t3_hs_count", hs_ops.size(), 16);
    for (int k = 0; k < 16; k++)
      check("t3_op", (k < hs_ops.size()) ? hs_ops[k] : -1, exp3[k]);
    check("t3_done_count", done_cnt, 1);
    check("t3_info", inst_if.o_conv_info, 9'o124);
    tick();

    // T4: empty runs issue nothing; done shows in the cycle after the accepting edge
    clear_logs();
    start_run(3'd1, 3'd1, 3'd1, 8'd0, 8'd4);
    wait_idle("t4a_timeout", 20);
    check("t4a_valid_cnt", valid_cnt, 0);
    check("t4a_done_count", done_cnt, 1);
    check("t4a_done_cycle", last_done_cyc, st_cyc + 1);
    tick();
    clear_logs();
    start_run(3'd1, 3'd1, 3'd1, 8'd3, 8'd0);
    wait_idle("t4b_timeout", 20);
    check("t4b_valid_cnt", valid_cnt, 0);
    check("t4b_done_count", done_cnt, 1);
    check("t4b_done_cycle", last_done_cyc, st_cyc + 1);
    tick();

    // T5: start mid-run with different config is ignored
    clear_logs();
    inst_if.i_inst_ready = 1'b1;
    start_run(3'd5, 3'd6, 3'd7, 8'd2, 8'd2);
    repeat (3) tick();
    p = 3'd1; q = 3'd1; s = 3'd1; nt = 8'd1; ni = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t5_timeout", 60);
    check("t5_hs_count", hs_ops.size(), 12);
    check("t5_done_count", done_cnt, 1);
    check("t5_info", inst_if.o_conv_info, 9'o567);
    tick();

    // T6: reset while CONV is offered, then a clean rerun of T1
    clear_logs();
    inst_if.i_inst_ready = 1'b1;
    start_run(3'd2, 3'd3, 3'd3, 8'd1, 8'd1);
    wait_conv("t6_conv_seen");
    inst_if.i_inst_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t6_valid", inst_if.o_inst_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_opcode", inst_if.o_opcode, 3'b000);
    rst = 1'b0;
    repeat (3) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_no_resume", valid_cnt, 1 + 1 + 1 + 2);
    clear_logs();
    inst_if.i_inst_ready = 1'b1;
    start_run(3'd2, 3'd3, 3'd3, 8'd1, 8'd1);
    wait_idle("t6_rerun_timeout", 50);
    t1_checks("t6_rerun");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
